aes_round_ctrl: RTL

- Sequencing controller for the iterative AES-128 encryption datapath (add-round-key, subbytes, shiftrows, mixcolumns, key expansion), one round per clock.
- Accepts a block-start handshake and steps the datapath through the initial key add, rounds 1..NR-1 and the final round, which skips mixcolumns.
- Generates the round index and round constant, then holds the result valid until the consumer takes it.
- Sits between the block-level input/output handshakes and the combinational round logic. State byte order is packed [15:0][7:0], byte 15 first.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_round_ctrl_if.sv | 27 ++
 rtl/aes_rcon_gen.sv | 30 +++
 rtl/aes_round_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round-constant constants,
// the GF(2^8) doubling used by both key expansion and mixcolumns.
package aes_pkg;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_POLY  = 8'h1B;
  localparam int         NR_AES128  = 10;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ROUND,
    FINAL,
    DONE
  } state_e;

  typedef struct packed {
    logic sel_init;
    logic state_en;
    logic skip_mixcol;
    logic out_valid;
    logic busy;
  } ctrl_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RCON_POLY : 8'h00);
  endfunction

  // Datapath strobes are a pure function of the state the FSM is entering.
  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t c;
    c.sel_init    = (s == INIT);
    c.state_en    = (s == INIT) || (s == ROUND) || (s == FINAL);
    c.skip_mixcol = (s == FINAL);
    c.out_valid   = (s == DONE);
    c.busy        = (s != IDLE);
    return c;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block handshake and datapath control bundle between the AES round controller
// and its surroundings; slave is the controller side.
interface aes_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic       sel_init;
  logic       state_en;
  logic       skip_mixcol;
  logic [3:0] round_idx;
  logic [7:0] rcon;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    output in_valid, flush, out_ready,
    input  in_ready, sel_init, state_en, skip_mixcol, round_idx, rcon,
           out_valid, busy
  );

  modport slave (
    input  in_valid, flush, out_ready,
    output in_ready, sel_init, state_en, skip_mixcol, round_idx, rcon,
           out_valid, busy
  );
endinterface

// File: rtl/aes_rcon_gen.sv
// Round-constant register for AES-128 key expansion: loads 01, doubles in
// GF(2^8) each advance, clears between blocks.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic       i_clr,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rcon <= 8'h00;
    end else if (i_load) begin
      r_rcon <= RCON_FIRST;
    end else if (i_adv) begin
      r_rcon <= xtime(r_rcon);
    end else if (i_clr) begin
      r_rcon <= 8'h00;
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: initial key add, NR-1 full rounds, a final
// round without mixcolumns, then holds the result until the consumer takes it.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
)
(
  input logic            clk,
  input logic            reset,
  aes_round_ctrl_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_e     r_state;
  state_e     w_nxt_state;
  logic [3:0] r_round_idx;
  logic [3:0] w_nxt_idx;
  logic [3:0] w_idx_inc;
  ctrl_t      r_ctrl;
  logic       r_idle;
  logic       w_rcon_load;
  logic       w_rcon_adv;
  logic       w_rcon_clr;
  logic [7:0] w_rcon;

  assign w_idx_inc = (r_round_idx >= NR_IDX) ? NR_IDX : r_round_idx + 4'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_round_idx;
    w_rcon_load = 1'b0;
    w_rcon_adv  = 1'b0;
    if (bus.flush) begin
      w_nxt_state = IDLE;
      w_nxt_idx   = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_idx = 4'd0;
          if (bus.in_valid) w_nxt_state = INIT;
        end
        INIT: begin
          w_nxt_state = ROUND;
          w_nxt_idx   = 4'd1;
          w_rcon_load = 1'b1;
        end
        // FINAL is chosen on the index compare; rcon just follows along.
        ROUND: begin
          w_nxt_idx  = w_idx_inc;
          w_rcon_adv = 1'b1;
          if (w_idx_inc == NR_IDX) w_nxt_state = FINAL;
        end
        FINAL: begin
          w_nxt_state = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            w_nxt_idx   = 4'd0;
            w_nxt_state = bus.in_valid ? INIT : IDLE;
          end
        end
        default: begin
          w_nxt_state = IDLE;
          w_nxt_idx   = 4'd0;
        end
      endcase
    end
  end

  assign w_rcon_clr = !(w_rcon_load || w_rcon_adv);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_round_idx <= 4'd0;
      r_ctrl      <= '0;
      r_idle      <= 1'b1;
    end else begin
      r_state     <= w_nxt_state;
      r_round_idx <= w_nxt_idx;
      r_ctrl      <= ctrl_decode(w_nxt_state);
      r_idle      <= (w_nxt_state == IDLE);
    end
  end

  aes_rcon_gen u_rcon (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_rcon_load),
    .i_adv  (w_rcon_adv),
    .i_clr  (w_rcon_clr),
    .o_rcon (w_rcon)
  );

  // out_ready is the only input reaching an output combinationally.
  assign bus.in_ready    = r_idle || (r_ctrl.out_valid && bus.out_ready);
  assign bus.sel_init    = r_ctrl.sel_init;
  assign bus.state_en    = r_ctrl.state_en;
  assign bus.skip_mixcol = r_ctrl.skip_mixcol;
  assign bus.out_valid   = r_ctrl.out_valid;
  assign bus.busy        = r_ctrl.busy;
  assign bus.round_idx   = r_round_idx;
  assign bus.rcon        = w_rcon;

endmodule
